// File: rtl/uart_rx_fifo.sv
// Receive-side frame buffer behind a UART receiver: one FIFO entry per DATA_VALID rising edge,
// registered pop interface, sticky overrun flag and a saturating error-frame counter.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter bit DROP_ERR   = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_DATA_VALID,
  input  logic                    RX_PAR_ERR,
  input  logic                    RX_FRM_ERR,
  input  logic                    RD_EN,
  input  logic                    CLR_OVR,
  output logic [DATA_WIDTH-1:0]   RD_DATA,
  output logic [1:0]              RD_ERR,
  output logic                    RD_VALID,
  output logic                    EMPTY,
  output logic                    FULL,
  output logic [$clog2(DEPTH):0]  COUNT,
  output logic                    OVERRUN,
  output logic [7:0]              ERR_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + 2;

  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          empty_reg, full_reg;
  logic          valid_reg;
  logic [EW-1:0] rd_word_reg;
  logic          rd_valid_reg;
  logic          overrun_reg;
  logic [7:0]    err_cnt_reg;

  logic wr_event, has_err, store_req, rd_accept, wr_accept, overrun_set;

  always_comb begin
    wr_event    = RX_DATA_VALID & ~valid_reg;
    has_err     = RX_PAR_ERR | RX_FRM_ERR;
    store_req   = wr_event & ~(DROP_ERR & has_err);
    rd_accept   = RD_EN & ~empty_reg;
    // A pop in the same cycle frees the slot the new frame goes into.
    wr_accept   = store_req & (~full_reg | rd_accept);
    overrun_set = store_req & full_reg & ~rd_accept;
    count_next  = count_reg;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= {RX_FRM_ERR, RX_PAR_ERR, RX_P_DATA};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_word_reg <= '0;
    end else if (rd_accept) begin
      rd_word_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      rd_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      valid_reg    <= RX_DATA_VALID;
      rd_valid_reg <= rd_accept;
      count_reg    <= count_next;
      empty_reg    <= (count_next == '0);
      full_reg     <= (count_next == (AW+1)'(DEPTH));
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (overrun_set) begin
        overrun_reg <= 1'b1;
      end else if (CLR_OVR) begin
        overrun_reg <= 1'b0;
      end
      if (wr_event && has_err && (err_cnt_reg != 8'hFF)) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  assign RD_DATA  = rd_word_reg[DATA_WIDTH-1:0];
  assign RD_ERR   = rd_word_reg[EW-1:DATA_WIDTH];
  assign RD_VALID = rd_valid_reg;
  assign EMPTY    = empty_reg;
  assign FULL     = full_reg;
  assign COUNT    = count_reg;
  assign OVERRUN  = overrun_reg;
  assign ERR_CNT  = err_cnt_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a table of single-cycle vectors plus hand sequences
// for fill/overrun, same-cycle corners, counter saturation, reset and the DROP_ERR variant.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       valid, par, frm, rd_en, clr_ovr;
  logic [7:0] rd_data;
  logic [1:0] rd_err;
  logic       rd_valid, empty, full, overrun;
  logic [4:0] count;
  logic [7:0] err_cnt;

  logic       d_valid, d_par, d_frm, d_rd_en;
  logic [7:0] d_rd_data;
  logic [1:0] d_rd_err;
  logic       d_rd_valid, d_empty, d_full, d_overrun;
  logic [4:0] d_count;
  logic [7:0] d_err_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .DROP_ERR(1'b0)) dut (
    .CLK(clk), .RST(rst), .RX_P_DATA(p_data), .RX_DATA_VALID(valid),
    .RX_PAR_ERR(par), .RX_FRM_ERR(frm), .RD_EN(rd_en), .CLR_OVR(clr_ovr),
    .RD_DATA(rd_data), .RD_ERR(rd_err), .RD_VALID(rd_valid), .EMPTY(empty),
    .FULL(full), .COUNT(count), .OVERRUN(overrun), .ERR_CNT(err_cnt)
  );

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .DROP_ERR(1'b1)) dut_drop (
    .CLK(clk), .RST(rst), .RX_P_DATA(p_data), .RX_DATA_VALID(d_valid),
    .RX_PAR_ERR(d_par), .RX_FRM_ERR(d_frm), .RD_EN(d_rd_en), .CLR_OVR(1'b0),
    .RD_DATA(d_rd_data), .RD_ERR(d_rd_err), .RD_VALID(d_rd_valid), .EMPTY(d_empty),
    .FULL(d_full), .COUNT(d_count), .OVERRUN(d_overrun), .ERR_CNT(d_err_cnt)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       pe, fe, rd, clr;
    int         cnt;
    logic       rdv;
    logic [7:0] rdd;
    logic [1:0] rde;
    logic       ovr;
    int         errc;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mk(logic v, logic [7:0] d, logic pe, logic fe, logic rd, logic clr,
                              int cnt, logic rdv, logic [7:0] rdd, logic [1:0] rde,
                              logic ovr, int errc);
    vec_t r;
    r.v = v; r.d = d; r.pe = pe; r.fe = fe; r.rd = rd; r.clr = clr;
    r.cnt = cnt; r.rdv = rdv; r.rdd = rdd; r.rde = rde; r.ovr = ovr; r.errc = errc;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic write_frame(input logic [7:0] d, input logic pe, input logic fe);
    p_data = d; par = pe; frm = fe; valid = 1'b1;
    tick();
    valid = 1'b0; par = 1'b0; frm = 1'b0;
    tick();
  endtask

  task automatic read_one(input string name, input logic [7:0] exp_d, input logic [1:0] exp_e);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({name, "_valid"}, 32'(rd_valid), 32'd1);
    chk({name, "_data"}, 32'({rd_err, rd_data}), 32'({exp_e, exp_d}));
  endtask

  initial begin
    logic [26:0] act, exp;

    // Table: single-cycle vectors; expectations are the outputs after that edge.
    //                v     d      pe    fe    rd    clr   cnt rdv   rdd    rde    ovr errc
    tbl[0]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 2'b00, 1'b0, 0);
    tbl[1]  = mk(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h00, 2'b00, 1'b0, 0);
    tbl[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h00, 2'b00, 1'b0, 0);
    tbl[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 8'hA5, 2'b00, 1'b0, 0);
    tbl[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'hA5, 2'b00, 1'b0, 0);
    tbl[5]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'hA5, 2'b00, 1'b0, 0);
    tbl[6]  = mk(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'hA5, 2'b00, 1'b0, 0);
    tbl[7]  = mk(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'hA5, 2'b00, 1'b0, 0);
    tbl[8]  = mk(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'hA5, 2'b00, 1'b0, 0);
    tbl[9]  = mk(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'hA5, 2'b00, 1'b0, 0);
    tbl[10] = mk(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'hA5, 2'b00, 1'b0, 0);
    tbl[11] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'hA5, 2'b00, 1'b0, 0);
    tbl[12] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 8'h3C, 2'b00, 1'b0, 0);
    tbl[13] = mk(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h3C, 2'b00, 1'b0, 1);
    tbl[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h3C, 2'b00, 1'b0, 1);
    tbl[15] = mk(1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 8'h3C, 2'b00, 1'b0, 2);
    tbl[16] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 8'h3C, 2'b00, 1'b0, 2);
    tbl[17] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 8'h55, 2'b01, 1'b0, 2);
    tbl[18] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 8'h66, 2'b10, 1'b0, 2);
    tbl[19] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h66, 2'b10, 1'b0, 2);
    tbl[20] = mk(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 8'h66, 2'b10, 1'b0, 2);
    tbl[21] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 8'h77, 2'b00, 1'b0, 2);
    tbl[22] = mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h77, 2'b00, 1'b0, 2);
    tbl[23] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h77, 2'b00, 1'b0, 2);
    tbl[24] = mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 8'h11, 2'b00, 1'b0, 2);
    tbl[25] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 8'h22, 2'b00, 1'b0, 2);
    tbl[26] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h22, 2'b00, 1'b0, 2);

    rst = 1'b1; p_data = '0; valid = 0; par = 0; frm = 0; rd_en = 0; clr_ovr = 0;
    d_valid = 0; d_par = 0; d_frm = 0; d_rd_en = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", 32'({empty, full, rd_valid, overrun}), 32'b1000);
    chk("rst_rd", 32'({rd_err, rd_data, err_cnt}), 32'd0);

    // DROP_ERR=1 instance: erroneous frames counted but not stored.
    p_data = 8'h55; d_par = 1'b1; d_valid = 1'b1; tick();
    d_valid = 1'b0; d_par = 1'b0; tick();
    p_data = 8'h66; d_frm = 1'b1; d_valid = 1'b1; tick();
    d_valid = 1'b0; d_frm = 1'b0; tick();
    chk("drop_count", 32'({d_count, d_empty}), 32'({5'd0, 1'b1}));
    chk("drop_errcnt", 32'({d_err_cnt, d_overrun}), 32'({8'd2, 1'b0}));
    p_data = 8'h99; d_valid = 1'b1; tick();
    d_valid = 1'b0; tick();
    chk("drop_good_count", 32'(d_count), 32'd1);
    d_rd_en = 1'b1; tick(); d_rd_en = 1'b0;
    chk("drop_good_read", 32'({d_rd_valid, d_rd_err, d_rd_data}), 32'({1'b1, 2'b00, 8'h99}));

    for (int i = 0; i < NV; i++) begin
      p_data = tbl[i].d; valid = tbl[i].v; par = tbl[i].pe; frm = tbl[i].fe;
      rd_en = tbl[i].rd; clr_ovr = tbl[i].clr;
      tick();
      act = {count, empty, full, rd_valid, rd_data, rd_err, overrun, err_cnt};
      exp = {5'(tbl[i].cnt), (tbl[i].cnt == 0), (tbl[i].cnt == 16), tbl[i].rdv,
             tbl[i].rdd, tbl[i].rde, tbl[i].ovr, 8'(tbl[i].errc)};
      vectors++;
      $display("vec %0d: count=%0d rd_valid=%b rd_data=%h rd_err=%b ovr=%b err_cnt=%0d",
               i, count, rd_valid, rd_data, rd_err, overrun, err_cnt);
      if (act !== exp) begin
        miscompares++;
        $display("FAIL vec%0d: got %h, expected %h", i, act, exp);
      end
    end
    valid = 0; par = 0; frm = 0; rd_en = 0; clr_ovr = 0;

    // Fill to 16, 17th frame lost, then drain in order across the pointer wrap.
    for (int i = 0; i < 17; i++) begin
      write_frame(8'(i), 1'b0, 1'b0);
      if (i == 15) chk("fill_full16", 32'({full, count, overrun}), 32'({1'b1, 5'd16, 1'b0}));
    end
    chk("fill_overrun", 32'({full, count, overrun}), 32'({1'b1, 5'd16, 1'b1}));
    for (int i = 0; i < 16; i++) read_one($sformatf("drain%0d", i), 8'(i), 2'b00);
    chk("drain_empty", 32'({empty, count}), 32'({1'b1, 5'd0}));
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    chk("clr_ovr", 32'(overrun), 32'd0);

    // Full with simultaneous write and read: no overrun, COUNT stays 16.
    for (int i = 0; i < 16; i++) write_frame(8'(8'h80 + i), 1'b0, 1'b0);
    p_data = 8'hEE; valid = 1'b1; rd_en = 1'b1; tick();
    valid = 1'b0; rd_en = 1'b0;
    chk("full_rw_count", 32'({count, full, overrun}), 32'({5'd16, 1'b1, 1'b0}));
    chk("full_rw_read", 32'({rd_valid, rd_data}), 32'({1'b1, 8'h80}));
    tick();
    // Overrun set beats a coincident clear.
    p_data = 8'hFF; valid = 1'b1; clr_ovr = 1'b1; tick();
    valid = 1'b0; clr_ovr = 1'b0;
    chk("ovr_vs_clr", 32'(overrun), 32'd1);
    tick();
    for (int i = 1; i < 16; i++) read_one($sformatf("drain2_%0d", i), 8'(8'h80 + i), 2'b00);
    read_one("drain2_ee", 8'hEE, 2'b00);
    chk("drain2_empty", 32'({empty, count}), 32'({1'b1, 5'd0}));

    // Error counter saturation: 2 already counted, 300 more must clamp at 255.
    for (int i = 0; i < 300; i++) write_frame(8'h33, 1'b1, 1'b0);
    chk("errcnt_sat", 32'(err_cnt), 32'd255);

    // Reset mid-stream with a full FIFO, strobe and read request active.
    p_data = 8'h44; valid = 1'b1; rd_en = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0; valid = 1'b0; rd_en = 1'b0;
    chk("rst2_count", 32'({count, empty, full}), 32'({5'd0, 1'b1, 1'b0}));
    chk("rst2_out", 32'({rd_valid, rd_data, rd_err, overrun, err_cnt}), 32'd0);
    tick();
    chk("rst2_no_rdv", 32'({rd_valid, count}), 32'd0);
    write_frame(8'h5A, 1'b0, 1'b0);
    read_one("post_rst", 8'h5A, 2'b00);
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
